div_unit: RTL and testbench
===========================

DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 The parameter list SHALL be XLEN, default 32: operand and result width; only 32 is supported.
REQ-002 Port CLK SHALL be: input, 1 bit, the single clock, rising-edge active.
REQ-003 Port RESET SHALL be: input, 1 bit, synchronous active-high reset.
REQ-004 Port START SHALL be: input, 1 bit, request to begin a division, sampled on the CLK edge.
REQ-005 Port DATA1 SHALL be: input, 32 bits, dividend.
REQ-006 Port DATA2 SHALL be: input, 32 bits, divisor.
REQ-007 Port SELECT SHALL be: input, 5 bits, ALU op code: 10001 DIV, 10101 DIVU, 11001 REM, 11101 REMU.
REQ-008 Port FLUSH SHALL be: input, 1 bit, abort of the operation in progress (pipeline flush).
REQ-009 Port RESULT SHALL be: output, 32 bits, quotient or remainder, registered.
REQ-010 Port BUSY SHALL be: output, 1 bit, high while an operation is in progress; the pipeline stalls EX on it.
REQ-011 Port DONE SHALL be: output, 1 bit, single-cycle pulse when RESULT is newly valid.

Function
REQ-012 The block SHALL implement states IDLE, ITER, FIX and FIN.
REQ-013 In IDLE, START=1 with a valid SELECT code SHALL latch the operands, op, |DATA1| and |DATA2| (absolute values for signed ops, raw values for unsigned ops) and the result sign, and SHALL move to ITER with the counter at 31.
REQ-014 START with any other SELECT code, or START while not IDLE, SHALL be ignored.
REQ-015 ITER SHALL perform one radix-2 restoring step per cycle over 32 cycles on a 33-bit partial remainder, decrementing the counter, and SHALL go to FIX after the step with counter 0.
REQ-016 FIX SHALL negate the quotient when signed and the signs differ, SHALL give the remainder the sign of the dividend, and SHALL load RESULT (quotient for DIV/DIVU, remainder for REM/REMU) before moving to FIN.
REQ-017 FIN SHALL assert DONE for exactly one cycle and SHALL return to IDLE.
REQ-018 Normal latency: START sampled at edge k SHALL give DONE=1 in the cycle after edge k+33.
REQ-019 BUSY SHALL be 1 in ITER and FIX, and SHALL be 0 in IDLE and FIN.
REQ-020 Divisor zero SHALL take the fast path IDLE->FIN, with DONE in the cycle after edge k+1.
REQ-021 On divisor zero, DIV/DIVU SHALL give 0xFFFFFFFF and REM/REMU SHALL give DATA1.
REQ-022 Signed overflow (DATA1=0x80000000, DATA2=0xFFFFFFFF) SHALL take the fast path, giving DIV 0x80000000 and REM 0.
REQ-023 FLUSH=1 SHALL force IDLE on the next edge from any state, SHALL drop BUSY, and SHALL suppress DONE; RESULT SHALL keep its previous value.
REQ-024 FLUSH and START in the same IDLE cycle: FLUSH SHALL win and START SHALL be ignored.
REQ-025 RESULT SHALL hold its last value until the next FIX or fast-path load.
REQ-026 START in the FIN cycle SHALL be ignored; back-to-back operations SHALL need one IDLE cycle.

Reset
REQ-027 RESET=1 at an edge SHALL set state to IDLE, RESULT to 0, BUSY to 0, DONE to 0 and the counter to 0, and SHALL clear the latched operands.
REQ-028 RESET mid-operation SHALL abandon the operation without a DONE pulse.
REQ-029 RESET SHALL take priority over FLUSH and START.

Structure
REQ-030 The four SELECT codes and the state encoding SHALL be defined in a shared package that the ALU and decoder also use.
REQ-031 A single sub-module, twos_neg (32-bit conditional two's-complement negate), SHALL be instantiated for the operand absolute values and the result sign fix.
REQ-032 The block SHALL contain no combinational path from inputs to RESULT, BUSY or DONE.

Verification
REQ-033 The bench SHALL cover: DIVU, DATA1=100, DATA2=7, START at edge k -> BUSY for 33 cycles, DONE after edge k+33, RESULT=14.
REQ-034 The bench SHALL cover: REM, DATA1=-100 (0xFFFFFF9C), DATA2=7 -> RESULT=0xFFFFFFFE (-2); DIV of the same operands -> 0xFFFFFFF2 (-14).
REQ-035 The bench SHALL cover: DIV, DATA2=0 -> DONE after edge k+1 with RESULT=0xFFFFFFFF; REMU, DATA1=0x1234, DATA2=0 -> RESULT=0x1234.
REQ-036 The bench SHALL cover: DIV 0x80000000 by 0xFFFFFFFF -> RESULT=0x80000000; REM of the same operands -> 0.
REQ-037 The bench SHALL cover: FLUSH at iteration 10 -> IDLE next cycle, BUSY=0, no DONE, RESULT unchanged; a new START then completes normally.
REQ-038 The bench SHALL cover: RESET at iteration 5 -> RESULT=0, BUSY=0, no DONE; START with SELECT=00000 (ADD) -> no BUSY, no DONE.

Source files
------------

// File: rtl/div_unit_pkg.sv
// Shared definitions for the divide unit: ALU op codes for the divide family
// and the sequencer state encoding used by the ALU, decoder and divider.
package div_unit_pkg;

  typedef enum logic [4:0] {
    OP_DIV  = 5'b10001,
    OP_DIVU = 5'b10101,
    OP_REM  = 5'b11001,
    OP_REMU = 5'b11101
  } div_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ITER = 2'd1,
    ST_FIX  = 2'd2,
    ST_FIN  = 2'd3
  } div_state_e;

  function automatic logic is_div_op(input logic [4:0] sel);
    return (sel == OP_DIV) || (sel == OP_DIVU) || (sel == OP_REM) || (sel == OP_REMU);
  endfunction

endpackage

// File: rtl/div_unit_twos_neg.sv
// Conditional two's-complement negate: passes the value through or negates it.
module twos_neg #(
  parameter int W = 32
) (
  input  logic [W-1:0] i_val,
  input  logic         i_neg,
  output logic [W-1:0] o_val
);

  assign o_val = i_neg ? (~i_val + W'(1)) : i_val;

endmodule

// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for DIV/DIVU/REM/REMU, one quotient bit
// per cycle, with a short path for divide-by-zero and signed overflow.
module div_unit
  import div_unit_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic            START,
  input  logic [XLEN-1:0] DATA1,
  input  logic [XLEN-1:0] DATA2,
  input  logic [4:0]      SELECT,
  input  logic            FLUSH,
  output logic [XLEN-1:0] RESULT,
  output logic            BUSY,
  output logic            DONE
);

  localparam int CNT_W = $clog2(XLEN);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(XLEN - 1);

  div_state_e       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [XLEN-1:0]  r_data1;
  logic [XLEN-1:0]  r_dvsr;
  logic [XLEN-1:0]  r_quo;
  logic [XLEN:0]    r_rem;
  logic [XLEN-1:0]  r_result;
  logic             r_is_rem;
  logic             r_neg_quo;
  logic             r_neg_rem;
  logic             r_fast;
  logic             r_busy;
  logic             r_done;

  logic            w_sel_signed;
  logic            w_sel_rem;
  logic            w_start_ok;
  logic            w_zero;
  logic            w_ovf;
  logic [XLEN-1:0] w_abs1;
  logic [XLEN-1:0] w_abs2;
  logic [XLEN:0]   w_shift;
  logic [XLEN:0]   w_diff;
  logic [XLEN-1:0] w_fix_in;
  logic            w_fix_neg;
  logic [XLEN-1:0] w_fixed;
  logic [XLEN-1:0] w_fast_res;

  assign w_sel_signed = (SELECT == OP_DIV) || (SELECT == OP_REM);
  assign w_sel_rem    = (SELECT == OP_REM) || (SELECT == OP_REMU);
  assign w_start_ok   = START && is_div_op(SELECT) && !r_fast;
  assign w_zero       = (DATA2 == '0);
  assign w_ovf        = w_sel_signed && (DATA1 == {1'b1, {(XLEN-1){1'b0}}}) && (DATA2 == '1);

  twos_neg #(.W(XLEN)) u_abs1 (.i_val(DATA1), .i_neg(w_sel_signed && DATA1[XLEN-1]), .o_val(w_abs1));
  twos_neg #(.W(XLEN)) u_abs2 (.i_val(DATA2), .i_neg(w_sel_signed && DATA2[XLEN-1]), .o_val(w_abs2));

  // Restoring step: shift the next dividend bit in, keep the difference if non-negative
  assign w_shift = {r_rem[XLEN-1:0], r_quo[XLEN-1]};
  assign w_diff  = w_shift - {1'b0, r_dvsr};

  assign w_fix_in  = r_is_rem ? r_rem[XLEN-1:0] : r_quo;
  assign w_fix_neg = r_is_rem ? r_neg_rem : r_neg_quo;
  twos_neg #(.W(XLEN)) u_fix (.i_val(w_fix_in), .i_neg(w_fix_neg), .o_val(w_fixed));

  // r_dvsr is zero only for a zero divisor; otherwise the short path was overflow
  assign w_fast_res = (r_dvsr == '0) ? (r_is_rem ? r_data1 : '1)
                                     : (r_is_rem ? '0 : {1'b1, {(XLEN-1){1'b0}}});

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_data1   <= '0;
      r_dvsr    <= '0;
      r_quo     <= '0;
      r_rem     <= '0;
      r_result  <= '0;
      r_is_rem  <= 1'b0;
      r_neg_quo <= 1'b0;
      r_neg_rem <= 1'b0;
      r_fast    <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else if (FLUSH) begin
      r_state <= ST_IDLE;
      r_fast  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_done <= 1'b0;
          // Short-path operands were latched last cycle; load the result now
          if (r_fast) begin
            r_fast   <= 1'b0;
            r_result <= w_fast_res;
            r_done   <= 1'b1;
            r_state  <= ST_FIN;
          end else if (w_start_ok) begin
            r_data1   <= DATA1;
            r_dvsr    <= w_abs2;
            r_quo     <= w_abs1;
            r_rem     <= '0;
            r_is_rem  <= w_sel_rem;
            r_neg_quo <= w_sel_signed && (DATA1[XLEN-1] ^ DATA2[XLEN-1]);
            r_neg_rem <= w_sel_signed && DATA1[XLEN-1];
            if (w_zero || w_ovf) begin
              r_fast <= 1'b1;
            end else begin
              r_cnt   <= CNT_MAX;
              r_busy  <= 1'b1;
              r_state <= ST_ITER;
            end
          end
        end
        ST_ITER: begin
          r_rem <= w_diff[XLEN] ? w_shift : w_diff;
          r_quo <= {r_quo[XLEN-2:0], ~w_diff[XLEN]};
          r_cnt <= r_cnt - 1'b1;
          if (r_cnt == '0) r_state <= ST_FIX;
        end
        ST_FIX: begin
          r_result <= w_fixed;
          r_busy   <= 1'b0;
          r_done   <= 1'b1;
          r_state  <= ST_FIN;
        end
        ST_FIN: begin
          r_done  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign RESULT = r_result;
  assign BUSY   = r_busy;
  assign DONE   = r_done;

endmodule

// File: tb/tb_div_unit.sv
// Bench for div_unit: cycle-level reference model compared every cycle plus
// directed vectors with hand-computed results and latencies.
module tb_div_unit;

  localparam logic [4:0] S_DIV  = 5'b10001;
  localparam logic [4:0] S_DIVU = 5'b10101;
  localparam logic [4:0] S_REM  = 5'b11001;
  localparam logic [4:0] S_REMU = 5'b11101;
  localparam logic [4:0] S_ADD  = 5'b00000;

  logic        CLK, RESET, START, FLUSH, BUSY, DONE;
  logic [31:0] DATA1, DATA2, RESULT;
  logic [4:0]  SELECT;

  int checks = 0;
  int errors = 0;
  logic chk_en = 1'b0;

  div_unit #(.XLEN(32)) dut (
    .CLK(CLK), .RESET(RESET), .START(START), .DATA1(DATA1), .DATA2(DATA2),
    .SELECT(SELECT), .FLUSH(FLUSH), .RESULT(RESULT), .BUSY(BUSY), .DONE(DONE)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic logic valid_op(input logic [4:0] s);
    return s == S_DIV || s == S_DIVU || s == S_REM || s == S_REMU;
  endfunction

  function automatic logic is_fast(input logic [4:0] s, input logic [31:0] a, input logic [31:0] b);
    return (b == 0) || ((s == S_DIV || s == S_REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
  endfunction

  function automatic logic [31:0] exp_res(input logic [4:0] s, input logic [31:0] a, input logic [31:0] b);
    logic sgn, rem;
    logic signed [31:0] sa, sb;
    sgn = (s == S_DIV) || (s == S_REM);
    rem = (s == S_REM) || (s == S_REMU);
    sa = a;
    sb = b;
    if (b == 0) return rem ? a : 32'hFFFF_FFFF;
    if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return rem ? 32'h0 : 32'h8000_0000;
    if (sgn) return rem ? 32'(sa % sb) : 32'(sa / sb);
    return rem ? a % b : a / b;
  endfunction

  // Reference model: an accepted op completes after a fixed latency
  logic        m_busy, m_done, m_active, was_done;
  logic [31:0] m_res, m_pend;
  int          m_left;

  always @(posedge CLK) begin
    if (RESET) begin
      m_busy = 0; m_done = 0; m_active = 0; m_res = 0; m_left = 0;
    end else if (FLUSH) begin
      m_busy = 0; m_done = 0; m_active = 0;
    end else begin
      was_done = m_done;
      m_done = 0;
      if (m_active) begin
        m_left = m_left - 1;
        if (m_left == 0) begin
          m_active = 0; m_busy = 0; m_done = 1; m_res = m_pend;
        end
      end else if (!was_done && START && valid_op(SELECT)) begin
        m_active = 1;
        m_pend = exp_res(SELECT, DATA1, DATA2);
        m_left = is_fast(SELECT, DATA1, DATA2) ? 1 : 33;
        m_busy = !is_fast(SELECT, DATA1, DATA2);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge CLK) begin
    if (chk_en) begin
      check("model RESULT", RESULT, m_res);
      check("model BUSY", {31'b0, BUSY}, {31'b0, m_busy});
      check("model DONE", {31'b0, DONE}, {31'b0, m_done});
    end
  end

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic start_op(input logic [4:0] s, input logic [31:0] a, input logic [31:0] b);
    START = 1; SELECT = s; DATA1 = a; DATA2 = b;
    tick();
    START = 0;
  endtask

  task automatic wait_done(output int n, output int bc);
    n = 0; bc = 0;
    while (!DONE && n < 40) begin
      if (BUSY) bc++;
      tick();
      n++;
    end
  endtask

  task automatic run_op(input string name, input logic [4:0] s, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int lat);
    int n, bc;
    start_op(s, a, b);
    wait_done(n, bc);
    check({name, " latency"}, n, lat);
    check({name, " result"}, RESULT, exp);
    tick();
  endtask

  int n, bc, cnt;

  initial begin
    RESET = 1; START = 0; FLUSH = 0; SELECT = 0; DATA1 = 0; DATA2 = 0;
    tick(); tick();
    check("reset RESULT", RESULT, 0);
    check("reset BUSY", {31'b0, BUSY}, 0);
    check("reset DONE", {31'b0, DONE}, 0);
    RESET = 0;
    chk_en = 1;
    tick();

    start_op(S_DIVU, 100, 7);
    wait_done(n, bc);
    check("divu latency", n, 33);
    check("divu busy cycles", bc, 33);
    check("divu result", RESULT, 14);
    START = 1; SELECT = S_DIVU; DATA1 = 50; DATA2 = 3;
    tick();
    START = 0;
    check("start in FIN ignored", {31'b0, BUSY}, 0);
    tick();

    run_op("rem neg", S_REM, 32'hFFFF_FF9C, 7, 32'hFFFF_FFFE, 33);
    run_op("div neg", S_DIV, 32'hFFFF_FF9C, 7, 32'hFFFF_FFF2, 33);
    run_op("div by zero", S_DIV, 32'd55, 0, 32'hFFFF_FFFF, 1);
    run_op("remu by zero", S_REMU, 32'h1234, 0, 32'h1234, 1);
    run_op("div ovf", S_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    run_op("rem ovf", S_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 1);
    run_op("divu 1000/3", S_DIVU, 1000, 3, 333, 33);

    start_op(S_DIV, 12345, 5);
    repeat (10) tick();
    FLUSH = 1;
    tick();
    FLUSH = 0;
    check("flush BUSY", {31'b0, BUSY}, 0);
    check("flush DONE", {31'b0, DONE}, 0);
    check("flush RESULT kept", RESULT, 333);
    cnt = 0;
    repeat (40) begin tick(); if (DONE) cnt++; end
    check("flush no DONE", cnt, 0);
    run_op("div after flush", S_DIV, 32'hFFFF_FFF9, 2, 32'hFFFF_FFFD, 33);

    START = 1; FLUSH = 1; SELECT = S_DIVU; DATA1 = 9; DATA2 = 2;
    tick();
    START = 0; FLUSH = 0;
    check("flush beats start", {31'b0, BUSY}, 0);
    tick(); tick();

    start_op(S_REMU, 50, 7);
    repeat (5) tick();
    RESET = 1;
    tick();
    RESET = 0;
    check("mid reset RESULT", RESULT, 0);
    check("mid reset BUSY", {31'b0, BUSY}, 0);
    check("mid reset DONE", {31'b0, DONE}, 0);
    start_op(S_ADD, 10, 3);
    cnt = 0;
    repeat (40) begin if (DONE || BUSY) cnt++; tick(); end
    check("add ignored", cnt, 0);

    run_op("divu max/1", S_DIVU, 32'hFFFF_FFFF, 1, 32'hFFFF_FFFF, 33);
    run_op("remu max/16", S_REMU, 32'hFFFF_FFFF, 16, 15, 33);
    run_op("div 7/-2", S_DIV, 7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 33);
    run_op("rem 7/-2", S_REM, 7, 32'hFFFF_FFFE, 1, 33);
    run_op("div min/2", S_DIV, 32'h8000_0000, 2, 32'hC000_0000, 33);
    run_op("divu min/max", S_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 0, 33);
    run_op("rem by zero neg", S_REM, 32'hFFFF_FF9C, 0, 32'hFFFF_FF9C, 1);

    tick();
    chk_en = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
